// File: rtl/led_output_ctrl_if.sv
// Configuration bus for led_output_ctrl: the host writes a pending LED mode
// and invert setting, issues apply events, and reads back status.
interface led_output_ctrl_if #(
  parameter int NUM_LEDS = 8
);
  logic [2*NUM_LEDS-1:0] ledout_wdata;
  logic                  invrt_wdata;
  logic                  cfg_wr;
  logic                  period_start;
  logic                  force_update;
  logic                  cfg_pending;
  logic                  cfg_applied;
  logic [2*NUM_LEDS-1:0] active_ledout;

  // Host side: drives writes and apply events, observes status.
  modport master (
    output ledout_wdata, invrt_wdata, cfg_wr, period_start, force_update,
    input  cfg_pending, cfg_applied, active_ledout
  );

  // Controller side.
  modport slave (
    input  ledout_wdata, invrt_wdata, cfg_wr, period_start, force_update,
    output cfg_pending, cfg_applied, active_ledout
  );
endinterface

// File: rtl/led_output_ctrl.sv
// LED output controller: double-buffered per-LED mode configuration.
// A write lands in a shadow register and is copied to the active register
// only at a PWM period boundary (or on force_update), so a mode change never
// glitches an LED mid-period. The active register decodes each LED to off,
// on, its individual PWM, or PWM gated by the group waveform, followed by a
// global invert and a fault override that forces the inactive level.
module led_output_ctrl #(
  parameter int NUM_LEDS = 8,
  parameter int OUT_REG  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  led_output_ctrl_if.slave    cfg_if,
  input  logic [NUM_LEDS-1:0] pwm_individual,
  input  logic                group_out,
  input  logic                fault_off,
  output logic [NUM_LEDS-1:0] led
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_apply;
  logic [2*NUM_LEDS-1:0] r_shadow_ledout;
  logic                  r_shadow_invrt;
  logic [2*NUM_LEDS-1:0] r_active_ledout;
  logic                  r_active_invrt;
  logic                  r_cfg_applied;
  logic [NUM_LEDS-1:0]   w_decoded;
  logic [NUM_LEDS-1:0]   w_led;

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and apply decision. An apply event only matters while a
  // configuration is pending; a write in the same cycle as an apply keeps
  // the FSM pending because the new data is not yet active.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_if.cfg_wr) begin
          w_state_nxt = ST_PENDING;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PENDING: begin
        w_apply = cfg_if.period_start | cfg_if.force_update;
        if (w_apply && !cfg_if.cfg_wr) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PENDING;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_apply     = 1'b0;
      end
    endcase
  end

  // Shadow register: every write overwrites it (last write wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_ledout <= '0;
      r_shadow_invrt  <= 1'b0;
    end else if (cfg_if.cfg_wr) begin
      r_shadow_ledout <= cfg_if.ledout_wdata;
      r_shadow_invrt  <= cfg_if.invrt_wdata;
    end
  end

  // Active register: takes the shadow value present before this edge, so a
  // coincident write applies the old shadow and stays pending with the new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_ledout <= '0;
      r_active_invrt  <= 1'b0;
    end else if (w_apply) begin
      r_active_ledout <= r_shadow_ledout;
      r_active_invrt  <= r_shadow_invrt;
    end
  end

  // Applied pulse: high for the one cycle following an active update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_applied <= 1'b0;
    end else begin
      r_cfg_applied <= w_apply;
    end
  end

  // Per-LED mode decode, invert, and fault override to the inactive level.
  always_comb begin
    w_decoded = '0;
    w_led     = '0;
    for (int n = 0; n < NUM_LEDS; n++) begin
      case (r_active_ledout[2*n +: 2])
        2'b00:   w_decoded[n] = 1'b0;
        2'b01:   w_decoded[n] = 1'b1;
        2'b10:   w_decoded[n] = pwm_individual[n];
        2'b11:   w_decoded[n] = group_out & pwm_individual[n];
        default: w_decoded[n] = 1'b0;
      endcase
    end
    if (fault_off) begin
      w_led = {NUM_LEDS{r_active_invrt}};
    end else begin
      w_led = w_decoded ^ {NUM_LEDS{r_active_invrt}};
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [NUM_LEDS-1:0] r_led;

      // Registered LED pins: one clock of latency from any input.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_led <= '0;
        end else begin
          r_led <= w_led;
        end
      end

      assign led = r_led;
    end else begin : g_out_comb
      assign led = w_led;
    end
  endgenerate

  assign cfg_if.cfg_pending   = (r_state == ST_PENDING);
  assign cfg_if.cfg_applied   = r_cfg_applied;
  assign cfg_if.active_ledout = r_active_ledout;

endmodule

// File: tb/tb_led_output_ctrl.sv
// Directed bench for led_output_ctrl with NUM_LEDS=4, OUT_REG=1.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_led_output_ctrl;

  localparam int NL = 4;

  logic          clk;
  logic          rst_n;
  logic [NL-1:0] pwm_individual;
  logic          group_out;
  logic          fault_off;
  logic [NL-1:0] led;

  int n_checks;
  int n_fail;

  led_output_ctrl_if #(.NUM_LEDS(NL)) cfg_bus ();

  led_output_ctrl #(.NUM_LEDS(NL), .OUT_REG(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_if         (cfg_bus.slave),
    .pwm_individual (pwm_individual),
    .group_out      (group_out),
    .fault_off      (fault_off),
    .led            (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic inv);
    cfg_bus.ledout_wdata = d;
    cfg_bus.invrt_wdata  = inv;
    cfg_bus.cfg_wr       = 1'b1;
  endtask

  task automatic idle_in();
    cfg_bus.cfg_wr       = 1'b0;
    cfg_bus.period_start = 1'b0;
    cfg_bus.force_update = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    cfg_bus.ledout_wdata = 8'hFF;
    cfg_bus.invrt_wdata  = 1'b1;
    cfg_bus.cfg_wr       = 1'b1;
    cfg_bus.period_start = 1'b1;
    cfg_bus.force_update = 1'b1;
    pwm_individual = 4'b1111;
    group_out      = 1'b1;
    fault_off      = 1'b0;

    // Inputs toggling under reset must be ignored.
    step(); step();
    chk_eq("rst_pending", 16'(cfg_bus.cfg_pending), 16'h0);
    chk_eq("rst_active", 16'(cfg_bus.active_ledout), 16'h00);
    chk_eq("rst_led", 16'(led), 16'h0);
    idle_in();
    rst_n = 1'b1;
    step();
    chk_eq("rel_led", 16'(led), 16'h0);
    chk_eq("rel_pending", 16'(cfg_bus.cfg_pending), 16'h0);
    chk_eq("rel_applied", 16'(cfg_bus.cfg_applied), 16'h0);
    chk_eq("rel_active", 16'(cfg_bus.active_ledout), 16'h00);

    // Mode decode: LED3=11, LED2=10, LED1=01, LED0=00, applied by period_start.
    pwm_individual = 4'b1100;
    group_out      = 1'b1;
    wr(8'b11_10_01_00, 1'b0);
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk_eq("wait_pending", 16'(cfg_bus.cfg_pending), 16'h1);
      chk_eq("wait_led", 16'(led), 16'h0);
      chk_eq("wait_applied", 16'(cfg_bus.cfg_applied), 16'h0);
      step();
    end
    cfg_bus.period_start = 1'b1;
    step();
    idle_in();
    chk_eq("ps_active", 16'(cfg_bus.active_ledout), 16'h00E4);
    chk_eq("ps_applied", 16'(cfg_bus.cfg_applied), 16'h1);
    chk_eq("ps_pending", 16'(cfg_bus.cfg_pending), 16'h0);
    chk_eq("ps_led_lag", 16'(led), 16'h0);
    step();
    chk_eq("ps_applied_once", 16'(cfg_bus.cfg_applied), 16'h0);
    chk_eq("dec_a", 16'(led), 16'b1110);
    pwm_individual = 4'b0100;
    #1;
    chk_eq("outreg_lag", 16'(led), 16'b1110);
    step();
    chk_eq("dec_b", 16'(led), 16'b0110);
    pwm_individual = 4'b1000;
    group_out      = 1'b0;
    step();
    chk_eq("dec_c", 16'(led), 16'b0010);

    // Last write wins; single applied pulse.
    wr(8'h55, 1'b0);
    step();
    wr(8'hAA, 1'b0);
    step();
    idle_in();
    step();
    chk_eq("lww_hold", 16'(cfg_bus.active_ledout), 16'h00E4);
    cfg_bus.period_start = 1'b1;
    step();
    idle_in();
    chk_eq("lww_active", 16'(cfg_bus.active_ledout), 16'h00AA);
    chk_eq("lww_applied", 16'(cfg_bus.cfg_applied), 16'h1);
    step();
    chk_eq("lww_applied_once", 16'(cfg_bus.cfg_applied), 16'h0);

    // Apply events in IDLE do nothing.
    cfg_bus.period_start = 1'b1;
    cfg_bus.force_update = 1'b1;
    step();
    idle_in();
    chk_eq("idle_ps_applied", 16'(cfg_bus.cfg_applied), 16'h0);
    step();
    chk_eq("idle_ps_applied2", 16'(cfg_bus.cfg_applied), 16'h0);

    // Write coincident with period_start in IDLE defers the apply.
    wr(8'h55, 1'b1);
    cfg_bus.period_start = 1'b1;
    step();
    idle_in();
    chk_eq("coinc_active", 16'(cfg_bus.active_ledout), 16'h00AA);
    chk_eq("coinc_pending", 16'(cfg_bus.cfg_pending), 16'h1);
    chk_eq("coinc_applied", 16'(cfg_bus.cfg_applied), 16'h0);
    cfg_bus.period_start = 1'b1;
    step();
    idle_in();
    chk_eq("inv_active", 16'(cfg_bus.active_ledout), 16'h0055);
    step();
    chk_eq("inv_led", 16'(led), 16'b0000);

    // Fault override forces the inactive (inverted) level.
    fault_off = 1'b1;
    #1;
    chk_eq("fault_lag", 16'(led), 16'b0000);
    step();
    chk_eq("fault_on", 16'(led), 16'b1111);
    fault_off = 1'b0;
    step();
    chk_eq("fault_off", 16'(led), 16'b0000);

    // Write plus apply while pending: old shadow applies, new one stays pending.
    wr(8'h0F, 1'b0);
    step();
    wr(8'hF0, 1'b0);
    cfg_bus.force_update = 1'b1;
    step();
    idle_in();
    chk_eq("both_active", 16'(cfg_bus.active_ledout), 16'h000F);
    chk_eq("both_pending", 16'(cfg_bus.cfg_pending), 16'h1);
    chk_eq("both_applied", 16'(cfg_bus.cfg_applied), 16'h1);
    cfg_bus.period_start = 1'b1;
    step();
    idle_in();
    chk_eq("both_active2", 16'(cfg_bus.active_ledout), 16'h00F0);
    chk_eq("both_pending2", 16'(cfg_bus.cfg_pending), 16'h0);

    // force_update applies immediately; later period_start is ignored.
    pwm_individual = 4'b1010;
    group_out      = 1'b1;
    wr(8'hFF, 1'b0);
    step();
    idle_in();
    cfg_bus.force_update = 1'b1;
    step();
    idle_in();
    chk_eq("fu_active", 16'(cfg_bus.active_ledout), 16'h00FF);
    chk_eq("fu_applied", 16'(cfg_bus.cfg_applied), 16'h1);
    step();
    chk_eq("fu_led", 16'(led), 16'b1010);
    cfg_bus.period_start = 1'b1;
    step();
    idle_in();
    chk_eq("fu_ps_applied", 16'(cfg_bus.cfg_applied), 16'h0);
    chk_eq("fu_ps_active", 16'(cfg_bus.active_ledout), 16'h00FF);

    // Reset while pending discards the pending configuration.
    wr(8'h55, 1'b0);
    step();
    idle_in();
    chk_eq("rp_pending", 16'(cfg_bus.cfg_pending), 16'h1);
    rst_n = 1'b0;
    #1;
    chk_eq("rp_async_active", 16'(cfg_bus.active_ledout), 16'h00);
    chk_eq("rp_async_pending", 16'(cfg_bus.cfg_pending), 16'h0);
    chk_eq("rp_async_led", 16'(led), 16'h0);
    step();
    rst_n = 1'b1;
    step();
    chk_eq("rp_pending2", 16'(cfg_bus.cfg_pending), 16'h0);
    chk_eq("rp_applied", 16'(cfg_bus.cfg_applied), 16'h0);
    cfg_bus.period_start = 1'b1;
    step();
    idle_in();
    chk_eq("rp_ps_applied", 16'(cfg_bus.cfg_applied), 16'h0);
    chk_eq("rp_ps_active", 16'(cfg_bus.active_ledout), 16'h00);
    step();
    chk_eq("rp_ps_applied2", 16'(cfg_bus.cfg_applied), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
